presc_tick_timer: RTL and testbench
===================================

Name: presc_tick_timer

Overview:
- Consumes one divided-clock tap from the prescaler, a free-running counter bit in the clk_i domain.
- Turns each rising edge of that tap into a one-cycle enable and counts those enables against a programmable period.
- Produces a periodic or one-shot tick, a PWM output and a status count.
- Drives the loopback design's LED heartbeat and USB housekeeping timeouts.

Parameters:
- CNT_W, 16, width of period register and tick counter.
- PWM_W, 8, width of duty value; compared against the low PWM_W bits of the counter.

Ports:
- clk_i  in  1  system clock.
- rstn_i  in  1  reset, synchronous, active-low.
- presc_i  in  1  prescaler tap (e.g. clk_div16_o); same clock domain, no synchroniser needed.
- start_i  in  1  one-cycle pulse: load period_i/duty_i/oneshot_i and (re)start.
- stop_i  in  1  one-cycle pulse: abort to IDLE.
- oneshot_i  in  1  mode sampled at start: 1 = single tick then IDLE, 0 = periodic.
- period_i  in  CNT_W  terminal count; a tick is produced every period_i+1 prescaler edges.
- duty_i  in  PWM_W  PWM high-time in prescaler edges.
- tick_o  out  1  one-cycle pulse at terminal count.
- busy_o  out  1  high in ARM or RUN.
- pwm_o  out  1  PWM output.
- count_o  out  CNT_W  current counter value.
- irq_o  out  1  sticky tick flag (optional feature).
- irq_clr_i  in  1  clears irq_o (optional feature).

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-low on rstn_i. All state is sampled on the posedge clk_i where rstn_i=0.
- Reset values: state=IDLE, presc_q=0, counter=0, period_q=0, duty_q=0, oneshot_q=0, tick_o=0, busy_o=0, pwm_o=0, count_o=0, irq_o=0.
- Edge detect:
  - presc_q <= presc_i every cycle.
  - en = presc_i & ~presc_q, combinational. Only rising edges count; a tap held high gives exactly one en.
- State machine, three states:
  - IDLE: counter held at 0, pwm_o=0. On start_i: latch period_i, duty_i, oneshot_i; go to ARM.
  - ARM: counter held at 0. Waits for the first en, so the tick phase aligns to the prescaler. On en: go to RUN, counter stays 0 (that edge is count 0).
  - RUN, on each en:
    - If counter==period_q: counter<=0, tick_o<=1 next cycle.
    - Then, if oneshot_q: go to IDLE. Otherwise stay in RUN.
    - Else counter<=counter+1.
  - RUN, no en: counter holds.
- Tick timing: tick_o is registered. It is high exactly one cycle: the cycle after the clock edge where en and terminal count coincide. Never high two consecutive cycles.
- period_q=0: a tick on every en after ARM.
- Counter width: counter never exceeds period_q, so no wrap is needed. period_q=2^CNT_W-1 is legal; the tick comes after 2^CNT_W edges.
- PWM:
  - pwm_o registered: (state==RUN) && (counter[PWM_W-1:0] < duty_q), using the post-update counter value.
  - duty_q=0 gives pwm_o constantly 0.
  - duty_q>period_q (in the low bits) gives pwm_o constantly 1 in RUN.
- busy_o registered: 1 when the next state is ARM or RUN.
- count_o = counter.
- start_i while ARM or RUN: relatch inputs, counter<=0, go to ARM. Any pending tick is not produced.
- stop_i: from any state, go to IDLE, counter<=0, pwm_o<=0. A tick_o already registered this cycle still completes.
- stop_i and start_i in the same cycle: stop wins.
- start_i coinciding with a terminal-count en: restart wins, no tick.
- Reset asserted mid-operation: all outputs take reset values on that edge, regardless of other inputs.

Optional Feature:
- Macro: PRESC_TICK_TIMER_IRQ_EN.
- Defined:
  - irq_o set on the cycle tick_o is high.
  - Cleared by irq_clr_i on the next edge; set wins over clear in the same cycle.
  - Cleared by stop_i only if irq_clr_i is also asserted.
- Undefined: irq_o tied 0, irq_clr_i ignored, no flag register.

Test Plan:
- Reset, then presc_i toggling every 8 clocks, period_i=3, oneshot_i=0, start_i -> ARM until the first rising edge; tick_o one-cycle pulses every 4 prescaler edges (64 clocks); count_o cycles 0,1,2,3.
- oneshot_i=1, period_i=2, start -> exactly one tick_o after 3 edges, then busy_o=0, state IDLE, count_o=0.
- period_i=7, duty_i=3 -> pwm_o high for counter 0..2, low for 3..7; duty_i=0 -> pwm_o never high.
- stop_i while RUN with counter=2 -> busy_o=0, pwm_o=0, count_o=0 next cycle, no further ticks. start_i and stop_i together -> remains IDLE.
- period_i=0 -> tick_o on every prescaler rising edge. presc_i held high 20 clocks -> only one count.
- IRQ_EN defined: tick sets irq_o; irq_clr_i alone clears it; irq_clr_i coinciding with tick keeps irq_o=1. rstn_i=0 mid-RUN -> all outputs 0 on that edge.

Source files
------------

// File: rtl/presc_tick_timer.sv
// presc_tick_timer: turns rising edges of a prescaler tap into count enables,
// counts them against a programmable period and produces a tick, a PWM output
// and the live count.
// Optional sticky tick flag: define PRESC_TICK_TIMER_IRQ_EN to build irq_o.
//
// Handshake: start_i and stop_i are single-cycle pulses sampled on posedge
// clk_i; there is no ready/ack, a pulse is always accepted on the edge it is
// seen. stop_i takes priority over start_i.
module presc_tick_timer #(
  parameter int CNT_W = 16,
  parameter int PWM_W = 8
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             presc_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             oneshot_i,
  input  logic [CNT_W-1:0] period_i,
  input  logic [PWM_W-1:0] duty_i,
  output logic             tick_o,
  output logic             busy_o,
  output logic             pwm_o,
  output logic [CNT_W-1:0] count_o,
  output logic             irq_o,
  input  logic             irq_clr_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_RUN  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             presc_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [PWM_W-1:0] duty_q, duty_d;
  logic             oneshot_q, oneshot_d;
  logic             tick_q, tick_d;
  logic             busy_q, busy_d;
  logic             pwm_q, pwm_d;
  logic             en;

  // Rising edge of the tap; a tap held high yields a single enable.
  assign en = presc_i & ~presc_q;

  // Next-state, counter and registered-output logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    duty_d    = duty_q;
    oneshot_d = oneshot_q;
    tick_d    = 1'b0;
    if (stop_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else if (start_i) begin
      // A restart discards any tick that would have fired on this edge.
      period_d  = period_i;
      duty_d    = duty_i;
      oneshot_d = oneshot_i;
      cnt_d     = '0;
      state_d   = S_ARM;
    end else begin
      case (state_q)
        S_IDLE: cnt_d = '0;
        S_ARM: begin
          // The aligning edge itself is count 0.
          cnt_d = '0;
          if (en) state_d = S_RUN;
        end
        S_RUN: begin
          if (en) begin
            if (cnt_q == period_q) begin
              cnt_d  = '0;
              tick_d = 1'b1;
              if (oneshot_q) state_d = S_IDLE;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
    pwm_d  = (state_d == S_RUN) && (cnt_d[PWM_W-1:0] < duty_q);
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q   <= S_IDLE;
      presc_q   <= 1'b0;
      cnt_q     <= '0;
      period_q  <= '0;
      duty_q    <= '0;
      oneshot_q <= 1'b0;
      tick_q    <= 1'b0;
      busy_q    <= 1'b0;
      pwm_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_i;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      duty_q    <= duty_d;
      oneshot_q <= oneshot_d;
      tick_q    <= tick_d;
      busy_q    <= busy_d;
      pwm_q     <= pwm_d;
    end
  end

  assign tick_o  = tick_q;
  assign busy_o  = busy_q;
  assign pwm_o   = pwm_q;
  assign count_o = cnt_q;

`ifdef PRESC_TICK_TIMER_IRQ_EN
  logic irq_q, irq_d;

  // Sticky flag rises together with tick_o; a new tick beats a clear.
  always_comb begin
    irq_d = irq_q;
    if (tick_d)         irq_d = 1'b1;
    else if (irq_clr_i) irq_d = 1'b0;
  end

  // Flag register.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) irq_q <= 1'b0;
    else         irq_q <= irq_d;
  end

  assign irq_o = irq_q;
`else
  logic unused_irq_clr;
  assign unused_irq_clr = irq_clr_i;
  assign irq_o          = 1'b0;
`endif

endmodule

// File: tb/tb_presc_tick_timer.sv
// Bench for presc_tick_timer: directed scenarios followed by random traffic,
// every cycle compared against an edge-counting reference model.
module tb_presc_tick_timer;
  localparam int CNT_W = 16;
  localparam int PWM_W = 8;
  localparam int EW    = CNT_W + 4;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic             rstn_i, presc_i, start_i, stop_i, oneshot_i, irq_clr_i;
  logic [CNT_W-1:0] period_i;
  logic [PWM_W-1:0] duty_i;
  logic             tick_o, busy_o, pwm_o, irq_o;
  logic [CNT_W-1:0] count_o;

  presc_tick_timer #(.CNT_W(CNT_W), .PWM_W(PWM_W)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .presc_i(presc_i), .start_i(start_i),
    .stop_i(stop_i), .oneshot_i(oneshot_i), .period_i(period_i),
    .duty_i(duty_i), .tick_o(tick_o), .busy_o(busy_o), .pwm_o(pwm_o),
    .count_o(count_o), .irq_o(irq_o), .irq_clr_i(irq_clr_i)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_ticks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Timing is described by how many tap edges have been seen since the
  // aligning edge; count and tick follow from modular arithmetic.
  int      m_mode;   // 0 idle, 1 waiting for aligning edge, 2 counting
  longint  m_edges;
  longint  m_per;
  int      m_duty;
  bit      m_one, m_prev, m_irq;

  task automatic model_step();
    bit     rise, tk, pw, bz;
    longint cnt;
    rise = presc_i && !m_prev;
    tk = 0; cnt = 0; pw = 0; bz = 0;
    if (!rstn_i) begin
      m_mode = 0; m_edges = 0; m_per = 0; m_duty = 0; m_one = 0; m_irq = 0;
    end else begin
      if (stop_i) begin
        m_mode = 0; m_edges = 0;
      end else if (start_i) begin
        m_per = period_i; m_duty = duty_i; m_one = oneshot_i;
        m_mode = 1; m_edges = 0;
      end else if (rise && m_mode == 1) begin
        m_mode = 2; m_edges = 0;
      end else if (rise && m_mode == 2) begin
        m_edges++;
        if (m_edges % (m_per + 1) == 0) begin
          tk = 1;
          if (m_one) begin m_mode = 0; m_edges = 0; end
        end
      end
      cnt = (m_mode == 2) ? m_edges % (m_per + 1) : 0;
      pw  = (m_mode == 2) && ((cnt % (1 << PWM_W)) < m_duty);
      bz  = (m_mode != 0);
`ifdef PRESC_TICK_TIMER_IRQ_EN
      if (tk) m_irq = 1;
      else if (irq_clr_i) m_irq = 0;
`endif
    end
    m_prev = rstn_i ? presc_i : 1'b0;
    exp_q.push_back({m_irq, tk, bz, pw, cnt[CNT_W-1:0]});
  endtask

  // ---------------- driver tasks ----------------
  // Inputs are applied 1 time unit after a posedge, outputs sampled likewise.
  task automatic cycle();
    logic [EW-1:0] e;
    model_step();
    @(posedge clk_i);
    #1;
    if (exp_q.size() == 0) begin
      check("queue_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("count_o", 32'(count_o), 32'(e[CNT_W-1:0]));
      check("pwm_o",   32'(pwm_o),   32'(e[CNT_W]));
      check("busy_o",  32'(busy_o),  32'(e[CNT_W+1]));
      check("tick_o",  32'(tick_o),  32'(e[CNT_W+2]));
      check("irq_o",   32'(irq_o),   32'(e[CNT_W+3]));
      if (e[CNT_W+2]) n_ticks++;
    end
    start_i = 0; stop_i = 0; irq_clr_i = 0;
    cyc++;
  endtask

  // Tap is a free-running divider bit: toggles every 2^sh clocks.
  task automatic run_div(input int n, input int sh);
    repeat (n) begin
      presc_i = ((cyc >> sh) & 1) != 0;
      cycle();
    end
  endtask

  task automatic start_cfg(input logic one, input int per, input int duty);
    oneshot_i = one;
    period_i  = CNT_W'(per);
    duty_i    = PWM_W'(duty);
    start_i   = 1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t0;
    rstn_i = 0; presc_i = 0; start_i = 0; stop_i = 0; oneshot_i = 0;
    irq_clr_i = 0; period_i = '0; duty_i = '0;
    m_mode = 0; m_edges = 0; m_per = 0; m_duty = 0; m_one = 0; m_prev = 0; m_irq = 0;
    #1;
    repeat (3) cycle();
    rstn_i = 1;
    cycle();

    // Periodic, period 3, tap toggles every 8 clocks.
    t0 = n_ticks;
    start_cfg(0, 3, 2);
    run_div(200, 3);
    check("periodic_tick_count", 32'(n_ticks - t0 >= 2), 32'd1);

    // One-shot after 3 edges, then idle.
    stop_i = 1; cycle();
    t0 = n_ticks;
    start_cfg(1, 2, 1);
    run_div(200, 3);
    check("oneshot_tick_count", 32'(n_ticks - t0), 32'd1);

    // PWM duty 3 over period 7, then duty 0.
    start_cfg(0, 7, 3);
    run_div(300, 2);
    start_cfg(0, 7, 0);
    run_div(150, 2);
    // duty above period: constantly high while counting.
    start_cfg(0, 4, 200);
    run_div(120, 2);

    // Stop mid-run, then start+stop together.
    start_cfg(0, 5, 2);
    run_div(45, 2);
    stop_i = 1; cycle();
    run_div(40, 2);
    start_cfg(0, 2, 1); stop_i = 1; cycle();
    run_div(20, 2);

    // Period 0: tick on every edge; tap held high counts once.
    start_cfg(0, 0, 1);
    run_div(40, 1);
    presc_i = 1;
    repeat (20) cycle();
    presc_i = 0;
    repeat (4) cycle();
    run_div(20, 1);

    // IRQ clear alone and clear coinciding with a tick (flag tied low if not built).
    start_cfg(0, 1, 1);
    run_div(30, 1);
    irq_clr_i = 1; cycle();
    repeat (40) begin
      irq_clr_i = ($urandom_range(0, 1) == 1);
      presc_i = ((cyc >> 1) & 1) != 0;
      cycle();
    end

    // Reset mid-run while other inputs are active.
    start_cfg(0, 3, 3);
    run_div(30, 1);
    rstn_i = 0; start_i = 1; presc_i = 1;
    cycle();
    rstn_i = 1;
    run_div(10, 1);

    // Restart coinciding with a terminal-count edge: no tick.
    start_cfg(0, 0, 0);
    run_div(12, 1);
    presc_i = 0; cycle();
    presc_i = 1; start_cfg(0, 0, 0); cycle();
    run_div(10, 1);

    // Random traffic.
    repeat (20000) begin
      if ($urandom_range(0, 2) == 0) presc_i = ~presc_i;
      if ($urandom_range(0, 59) == 0) begin
        if ($urandom_range(0, 4) == 0)
          start_cfg($urandom_range(0, 1) == 1, $urandom_range(0, 300), $urandom_range(0, 255));
        else
          start_cfg($urandom_range(0, 1) == 1, $urandom_range(0, 6), $urandom_range(0, 8));
      end
      if ($urandom_range(0, 149) == 0) stop_i = 1;
      if ($urandom_range(0, 9) == 0) irq_clr_i = 1;
      rstn_i = ($urandom_range(0, 1999) != 0);
      cycle();
    end
    rstn_i = 1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
